// File: rtl/uop_queue.sv
// Decoded micro-op queue between a 2-wide decoder and a 1-wide register-read stage.
// Circular buffer with head/tail pointers, flush, illegal-pattern flag and decoder stall counter.

package DecoderTypes;
    typedef struct packed {
        logic [31:0] rip_val;
        logic [7:0]  opcode;
        logic [4:0]  dst;
        logic [4:0]  src0;
        logic [4:0]  src1;
    } micro_op_t;
endpackage

module uop_queue
    import DecoderTypes::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [1:0]                 enq_valid,
    input  micro_op_t                  enq_uop0,
    input  micro_op_t                  enq_uop1,
    output logic                       enq_ready,
    output logic                       enq_err,
    output logic                       deq_valid,
    output micro_op_t                  deq_uop,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                stall_cycles
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    micro_op_t       storage_r [DEPTH];
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic            enq_err_r;
    logic [31:0]     stall_r;

    logic            accept_s;
    logic            deq_s;
    logic            stall_s;
    logic            illegal_s;
    logic [CW-1:0]   n_enq_s;
    logic [CW-1:0]   n_deq_s;
    logic [PW-1:0]   tail_next_slot_s;

    // Ready is judged on the registered occupancy only; a same-cycle dequeue earns no credit.
    assign enq_ready    = (count_r <= CW'(DEPTH - 2));
    assign deq_valid    = (count_r != {CW{1'b0}});
    assign deq_uop      = deq_valid ? storage_r[head_r] : '0;
    assign count        = count_r;
    assign enq_err      = enq_err_r;
    assign stall_cycles = stall_r;

    // Per-cycle enqueue/dequeue decisions; flush overrides both.
    always_comb begin
        accept_s         = 1'b0;
        deq_s            = 1'b0;
        stall_s          = 1'b0;
        illegal_s        = 1'b0;
        n_enq_s          = {CW{1'b0}};
        n_deq_s          = {CW{1'b0}};
        tail_next_slot_s = tail_r + PW'(1'b1);
        illegal_s        = (enq_valid == 2'b10);
        if (flush) begin
            accept_s = 1'b0;
            deq_s    = 1'b0;
            stall_s  = 1'b0;
        end else begin
            accept_s = enq_ready && enq_valid[0];
            deq_s    = deq_valid && deq_ready;
            stall_s  = enq_valid[0] && !enq_ready;
        end
        if (accept_s) begin
            n_enq_s = enq_valid[1] ? CW'(2'd2) : CW'(2'd1);
        end else begin
            n_enq_s = {CW{1'b0}};
        end
        if (deq_s) begin
            n_deq_s = CW'(1'b1);
        end else begin
            n_deq_s = {CW{1'b0}};
        end
    end

    // Pointer, occupancy, error pulse and stall counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r    <= {PW{1'b0}};
            tail_r    <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            enq_err_r <= 1'b0;
            stall_r   <= 32'd0;
        end else begin
            enq_err_r <= illegal_s;
            if (stall_s && (stall_r != 32'hFFFF_FFFF)) begin
                stall_r <= stall_r + 32'd1;
            end
            if (flush) begin
                head_r  <= {PW{1'b0}};
                tail_r  <= {PW{1'b0}};
                count_r <= {CW{1'b0}};
            end else begin
                tail_r  <= tail_r + n_enq_s[PW-1:0];
                count_r <= count_r + n_enq_s - n_deq_s;
                if (deq_s) begin
                    head_r <= head_r + PW'(1'b1);
                end
            end
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            storage_r[tail_r] <= enq_uop0;
            if (enq_valid[1]) begin
                storage_r[tail_next_slot_s] <= enq_uop1;
            end
        end
    end

endmodule

// File: doc/uop_queue.md
UOP_QUEUE -- requirements
Module: uop_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue capacity in micro-ops (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  discard all queued micro-ops (redirect/mispredict).
REQ-005 SHALL have port enq_valid  input  2  bit0 = slot0 valid, bit1 = slot1 valid, from decoder.
REQ-006 SHALL have ports enq_uop0 and enq_uop1  input  micro_op_t (DecoderTypes)  micro-ops for slot0 and slot1.
REQ-007 SHALL have port enq_ready  output  1  queue can accept a 2-wide enqueue this cycle.
REQ-008 SHALL have port enq_err  output  1  one-cycle pulse on illegal enq_valid pattern.
REQ-009 SHALL have port deq_valid  output  1  head entry present.
REQ-010 SHALL have port deq_uop  output  micro_op_t  head micro-op.
REQ-011 SHALL have port deq_ready  input  1  consumer (register-read/execute) takes head.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port stall_cycles  output  32  saturating count of decoder stall cycles.

Function
REQ-014 SHALL assert enq_ready iff registered count <= DEPTH-2; same-cycle dequeue not credited.
REQ-015 SHALL accept enqueue iff enq_ready and enq_valid[0]; slot0 written at tail, slot1 at tail+1 iff enq_valid[1].
REQ-016 SHALL treat enq_valid = 2'b10 as illegal: nothing written, enq_err high the following cycle for exactly one cycle.
REQ-017 SHALL advance tail by number of accepted micro-ops (0, 1 or 2), modulo DEPTH.
REQ-018 SHALL assert deq_valid iff count != 0; deq_uop = storage[head] combinationally, all-zero when count == 0.
REQ-019 SHALL dequeue iff deq_valid and deq_ready; head advances by 1 modulo DEPTH.
REQ-020 SHALL update count = count + n_enq - n_deq in one cycle when enqueue and dequeue coincide.
REQ-021 SHALL preserve FIFO order: slot0 before slot1, older cycles before newer.
REQ-022 SHALL give flush priority over same-cycle enqueue and dequeue: head, tail, count -> 0; no entry written; deq_valid low next cycle.
REQ-023 SHALL increment stall_cycles each cycle enq_valid[0] && !enq_ready && !flush, saturating at 32'hFFFF_FFFF.
REQ-024 SHALL latency: micro-op enqueued in cycle N visible at deq_uop in cycle N+1 at the earliest.
REQ-025 SHALL wrap head and tail pointers across DEPTH-1 -> 0 without loss or duplication, including slot1 landing at index 0.
REQ-026 SHALL ignore deq_ready when deq_valid is low (no pointer or count change).

Reset
REQ-027 SHALL on reset_n low, immediately: head = tail = 0, count = 0, deq_valid = 0, deq_uop = 0, enq_ready = 1, enq_err = 0, stall_cycles = 0.
REQ-028 SHALL not reset storage array contents.
REQ-029 SHALL on reset mid-operation discard all entries; first post-reset enqueue lands at index 0.

Verification
REQ-030 SHALL cover 2-wide fill: enq_valid = 2'b11 for 4 cycles, deq_ready = 0 -> count = 8, enq_ready low after count reaches 8 (low once count >= 7), stall_cycles increments while enq_valid held.
REQ-031 SHALL cover order and wrap: enqueue rip_val 1..12 mixed 1-/2-wide with continuous deq_ready -> deq_uop.rip_val sequence 1..12, no gaps, pointers wrap.
REQ-032 SHALL cover simultaneous enq/deq: count = 6, enq_valid = 2'b11, deq_ready = 1 -> count = 7 next cycle, enq_ready low.
REQ-033 SHALL cover flush: count = 5, flush with enq_valid = 2'b11 and deq_ready = 1 -> count = 0, deq_valid = 0 next cycle, flushed micro-ops never appear.
REQ-034 SHALL cover illegal pattern: enq_valid = 2'b10 -> count unchanged, enq_err = 1 for exactly one cycle.
REQ-035 SHALL cover async reset: reset_n low mid-cycle at count = 4 -> count = 0, deq_valid = 0 before next clk edge.
